mem_responder: RTL and testbench

- Simulated memory-side endpoint of the proc2mem/mem2proc bus: the responder that the datapath's initiator talks to.
- Accepts BUS_LOAD/BUS_STORE commands and returns a transaction tag the same cycle. Completes each accepted transaction in order, exactly LATENCY cycles later.
- Backs a DEPTH-entry 64-bit storage array. Used as the memory model in datapath/negator/encryption benches.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 18 +
 rtl/mem_resp_delay_line.sv | 24 ++
 rtl/mem_responder.sv | 67 ++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared proc2mem/mem2proc command codes, tag type and in-flight request record.
package mem_bus_pkg;
    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;
    localparam int MEM_IDX_W = 16;
    typedef logic [3:0] mem_tag_t;
    typedef struct packed {
        logic                 valid;
        mem_tag_t             tag;
        logic [1:0]           cmd;
        logic [MEM_IDX_W-1:0] index;
        logic [63:0]          data;
    } mem_req_t;
    // Tag 0 means "nothing", so the allocator cycles 1..15.
    function automatic mem_tag_t next_tag(input mem_tag_t t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: proc2mem request / mem2proc response bus between initiator and memory.
interface mem_responder_if;
    import mem_bus_pkg::*;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_address;
    logic [63:0] proc2mem_data;
    mem_tag_t    mem2proc_reponse;
    logic [63:0] mem2proc_data;
    mem_tag_t    mem2proc_tag;
    modport master (
        output proc2mem_command, proc2mem_address, proc2mem_data,
        input  mem2proc_reponse, mem2proc_data, mem2proc_tag
    );
    modport slave (
        input  proc2mem_command, proc2mem_address, proc2mem_data,
        output mem2proc_reponse, mem2proc_data, mem2proc_tag
    );
endinterface

// File: rtl/mem_resp_delay_line.sv
// mem_resp_delay_line: fixed-depth shift register carrying accepted requests to completion.
module mem_resp_delay_line
    import mem_bus_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic     clock,
    input  logic     reset,
    input  mem_req_t i_req,
    output mem_req_t o_req
);
    mem_req_t r_stage [STAGES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_req;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_req = r_stage[STAGES-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: in-order fixed-latency memory endpoint with tag allocation and outstanding limit.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DEPTH           = 1024
) (
    input logic            clock,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0] r_mem [DEPTH];
    logic [3:0]  r_count;
    mem_tag_t    r_next_tag;
    mem_tag_t    r_tag;
    logic [63:0] r_data;
    logic        w_acc;
    mem_req_t    w_in;
    mem_req_t    w_out;
    logic [AW-1:0] w_idx;
    logic        w_unused;

    assign w_acc = (bus.proc2mem_command == BUS_LOAD || bus.proc2mem_command == BUS_STORE)
                   && r_count < 4'(MAX_OUTSTANDING);
    assign bus.mem2proc_reponse = w_acc ? r_next_tag : '0;
    assign w_in = '{valid: w_acc, tag: r_next_tag, cmd: bus.proc2mem_command,
                    index: MEM_IDX_W'(bus.proc2mem_address[AW+1:2]), data: bus.proc2mem_data};
    assign w_idx = w_out.index[AW-1:0];
    assign w_unused = ^{bus.proc2mem_address, w_out.index};

    // The output register is the last of the LATENCY stages.
    mem_resp_delay_line #(.STAGES(LATENCY - 1)) u_delay (
        .clock(clock),
        .reset(reset),
        .i_req(w_in),
        .o_req(w_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_next_tag <= 4'd1;
            r_tag      <= '0;
            r_data     <= '0;
        end else begin
            r_count <= r_count + 4'(w_acc) - 4'(r_tag != '0);
            if (w_acc) r_next_tag <= next_tag(r_next_tag);
            r_tag  <= w_out.valid ? w_out.tag : '0;
            r_data <= (w_out.valid && w_out.cmd == BUS_LOAD) ? r_mem[w_idx] : '0;
        end
    end

    // Store lands on the completion edge so the next cycle's load already sees it.
    always_ff @(posedge clock) begin
        if (w_out.valid && w_out.cmd == BUS_STORE) r_mem[w_idx] <= w_out.data;
    end

    assign bus.mem2proc_tag  = r_tag;
    assign bus.mem2proc_data = r_data;

    a_count: assert property (@(posedge clock) disable iff (!reset) r_count <= 4'(MAX_OUTSTANDING));
    a_tag:   assert property (@(posedge clock) disable iff (!reset)
                              (r_tag != '0) |=> (r_tag != $past(r_tag)));
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a transaction-level model.
module tb_mem_responder;
    import mem_bus_pkg::*;
    localparam int LAT = 4;
    localparam int MAXO = 4;
    localparam int DEPTH = 1024;

    logic clock = 0;
    logic reset;
    mem_responder_if bus();

    mem_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          done;
        logic [1:0]  cmd;
        int          idx;
        logic [63:0] data;
        mem_tag_t    tag;
    } txn_t;

    txn_t        q[$];
    logic [63:0] mmem [DEPTH];
    bit          mknown [DEPTH];
    int          ntag = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    mem_tag_t    o_rsp, o_tag, e_rsp, e_tag;
    logic [63:0] o_data, e_data;
    bit          e_dk;

    function automatic void model_reset();
        foreach (q[i]) if (q[i].cmd == BUS_STORE) mknown[q[i].idx] = 0;
        q.delete();
        ntag = 1;
    endfunction

    task automatic tick(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        txn_t t;
        bus.proc2mem_command = c;
        bus.proc2mem_address = a;
        bus.proc2mem_data    = d;
        @(negedge clock);
        o_rsp  = bus.mem2proc_reponse;
        o_tag  = bus.mem2proc_tag;
        o_data = bus.mem2proc_data;
        while (q.size() > 0 && q[0].done < cyc) void'(q.pop_front());
        e_tag = 0; e_data = 0; e_dk = 1; e_rsp = 0;
        if (q.size() > 0 && q[0].done == cyc) begin
            e_tag = q[0].tag;
            if (q[0].cmd == BUS_LOAD) begin
                e_data = mmem[q[0].idx];
                e_dk   = mknown[q[0].idx];
            end else begin
                mmem[q[0].idx]   = q[0].data;
                mknown[q[0].idx] = 1;
            end
        end
        if ((c == BUS_LOAD || c == BUS_STORE) && q.size() < MAXO) begin
            e_rsp  = 4'(ntag);
            t.done = cyc + LAT;
            t.cmd  = c;
            t.idx  = int'((a >> 2) % DEPTH);
            t.data = d;
            t.tag  = 4'(ntag);
            q.push_back(t);
            ntag = ntag % 15 + 1;
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.proc2mem_command = BUS_NONE;
        reset = 0;
        model_reset();
        @(posedge clock); #1;
        reset = 1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_address = '0;
        bus.proc2mem_data    = '0;
        reset = 1;
        #2 reset = 0;
        repeat (2) @(posedge clock);
        #1;
        if (bus.mem2proc_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", bus.mem2proc_tag); end
        if (bus.mem2proc_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.mem2proc_data); end
        total += 2;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick(BUS_NONE, 64'h0, 64'h0);
            if (o_rsp !== 4'd0 || o_tag !== 4'd0 || o_data !== 64'd0) begin
                bad++; $display("FAIL reset_idle cyc=%0d got rsp=%0d tag=%0d data=%h exp all 0", cyc, o_rsp, o_tag, o_data);
            end
            total++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick(i == 0 ? BUS_STORE : (i == 5 ? BUS_LOAD : BUS_NONE), 64'h10, 64'hDEADBEEF_00000001);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL basic_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL basic_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 3 : 2;
            if (i == 0 && o_rsp !== 4'd1) begin bad++; $display("FAIL basic_first_rsp got=%0d exp=1", o_rsp); end
            if (i == 4 && (o_tag !== 4'd1 || o_data !== 64'd0)) begin
                bad++; $display("FAIL basic_store_done got tag=%0d data=%h exp tag=1 data=0", o_tag, o_data);
            end
            if (i == 9 && (o_tag !== 4'd2 || o_data !== 64'hDEADBEEF_00000001)) begin
                bad++; $display("FAIL basic_load_done got tag=%0d data=%h exp tag=2 data=deadbeef00000001", o_tag, o_data);
            end
            if (i == 0 || i == 4 || i == 9) total++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 ? BUS_STORE : (i == 1 ? BUS_LOAD : BUS_NONE), 64'h20, 64'h5);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL b2b_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL b2b_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 3 : 2;
            if (i == 5 && (o_tag !== 4'd2 || o_data !== 64'h5)) begin
                bad++; $display("FAIL b2b_load got tag=%0d data=%h exp tag=2 data=5", o_tag, o_data);
            end
            if (i == 5) total++;
        end
    endtask

    task automatic test_full();
        mem_tag_t want [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        int k;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(BUS_LOAD, 64'h10, 64'h0);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL full_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_rsp !== want[i]) begin bad++; $display("FAIL full_seq i=%0d got=%0d exp=%0d", i, o_rsp, want[i]); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL full_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            total += 3;
        end
        for (k = 0; k < 10; k++) begin
            tick(BUS_LOAD, 64'h10, 64'h0);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL full_retry_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            total++;
            if (o_rsp != 0) break;
        end
        if (k !== 0 || o_rsp !== 4'd5) begin bad++; $display("FAIL full_reissue got retries=%0d rsp=%0d exp retries=0 rsp=5", k, o_rsp); end
        total++;
        for (int i = 0; i < LAT + 4; i++) begin
            tick(BUS_NONE, 64'h0, 64'h0);
            if (o_tag !== e_tag) begin bad++; $display("FAIL full_drain_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL full_drain_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 2 : 1;
        end
    endtask

    task automatic test_tag_wrap();
        int acc = 0;
        int cmp = 0;
        do_reset();
        for (int i = 0; i < 200 && (acc < 16 || cmp < 16); i++) begin
            tick(acc < 16 ? BUS_LOAD : BUS_NONE, 64'h10, 64'h0);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL wrap_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL wrap_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            total += 2;
            if (o_rsp != 0) begin
                if (o_rsp !== 4'(acc % 15 + 1)) begin bad++; $display("FAIL wrap_rsp_seq n=%0d got=%0d exp=%0d", acc, o_rsp, acc % 15 + 1); end
                total++;
                acc++;
            end
            if (o_tag != 0) begin
                if (o_tag !== 4'(cmp % 15 + 1)) begin bad++; $display("FAIL wrap_tag_seq n=%0d got=%0d exp=%0d", cmp, o_tag, cmp % 15 + 1); end
                total++;
                cmp++;
            end
        end
        if (acc != 16 || cmp != 16) begin bad++; $display("FAIL wrap_count got acc=%0d done=%0d exp 16/16", acc, cmp); end
        total++;
    endtask

    task automatic test_alias();
        logic [63:0] v = {$urandom, $urandom};
        bit seen = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(i == 0 ? BUS_STORE : (i == 1 ? 2'b11 : (i == 2 ? BUS_LOAD : BUS_NONE)),
                 i == 2 ? 64'h10 + 64'(4 * DEPTH) : 64'h10, v);
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL alias_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL alias_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL alias_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 3 : 2;
            if (i == 1 && o_rsp !== 4'd0) begin bad++; $display("FAIL alias_cmd11 got=%0d exp=0", o_rsp); end
            if (i == 1) total++;
            if (o_tag == 4'd2) begin
                seen = 1;
                if (o_data !== v) begin bad++; $display("FAIL alias_load got=%h exp=%h", o_data, v); end
                total++;
            end
        end
        if (!seen) begin bad++; $display("FAIL alias_seen got=0 exp=1"); end
        total++;
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [63:0] a;
        for (int i = 0; i < 8; i++) begin
            tick(BUS_STORE, 64'h400 + 64'(4 * i), {$urandom, $urandom});
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL rand_init_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            total++;
        end
        for (int i = 0; i < 200; i++) begin
            c = 2'($urandom_range(0, 3));
            a = 64'h400 + 64'(4 * $urandom_range(0, 7)) + 64'(4 * DEPTH * $urandom_range(0, 2)) + 64'($urandom_range(0, 3));
            tick(i < 190 ? c : BUS_NONE, a, {$urandom, $urandom});
            if (o_rsp !== e_rsp) begin bad++; $display("FAIL rand_rsp cyc=%0d got=%0d exp=%0d", cyc, o_rsp, e_rsp); end
            if (o_tag !== e_tag) begin bad++; $display("FAIL rand_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 3 : 2;
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(BUS_STORE, 64'h800 + 64'(4 * i), {$urandom, $urandom});
            if (o_rsp !== 4'(i + 1)) begin bad++; $display("FAIL mid_rsp i=%0d got=%0d exp=%0d", i, o_rsp, i + 1); end
            total++;
        end
        bus.proc2mem_command = BUS_NONE;
        reset = 0;
        model_reset();
        #1;
        if (bus.mem2proc_tag !== 4'd0 || bus.mem2proc_data !== 64'd0) begin
            bad++; $display("FAIL mid_async got tag=%0d data=%h exp 0", bus.mem2proc_tag, bus.mem2proc_data);
        end
        total++;
        @(posedge clock); #1;
        reset = 1;
        cyc++;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick(BUS_NONE, 64'h0, 64'h0);
            if (o_tag !== 4'd0) begin bad++; $display("FAIL mid_dropped cyc=%0d got=%0d exp=0", cyc, o_tag); end
            total++;
        end
        tick(BUS_LOAD, 64'h10, 64'h0);
        if (o_rsp !== 4'd1) begin bad++; $display("FAIL mid_next_tag got=%0d exp=1", o_rsp); end
        total++;
        for (int i = 0; i < LAT + 1; i++) begin
            tick(BUS_NONE, 64'h0, 64'h0);
            if (o_tag !== e_tag) begin bad++; $display("FAIL mid_drain_tag cyc=%0d got=%0d exp=%0d", cyc, o_tag, e_tag); end
            if (e_dk && o_data !== e_data) begin bad++; $display("FAIL mid_drain_data cyc=%0d got=%h exp=%h", cyc, o_data, e_data); end
            total += e_dk ? 2 : 1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_tag_wrap();
        test_alias();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
